// File: rtl/decode_3_8_bits_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the 3-to-8 register-select decoder
//               and the control unit's Rin/Rout select vectors.
//               DEC_SEL_W : width of an Rx/Ry instruction field
//               DEC_OUT_W : width of a register-select vector (R0..R7)
//               reg_sel_t : one-hot register-select vector, bit 7 = R0
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int DEC_SEL_W = 3;
    localparam int DEC_OUT_W = 8;

    typedef logic [DEC_OUT_W-1:0] reg_sel_t;

endpackage : decode_pkg
`default_nettype wire

// File: rtl/decode_3_8_bits.sv
`default_nettype none
// ============================================================================
// Module      : decode_3_8_bits
// Description : One-hot decoder with enable that turns an Rx/Ry field into an
//               R0..R7 select vector. Provides a combinational output and a
//               copy for downstream logic.
//
//               Build option DECODE_3_8_BITS_REG_OUT_EN:
//                 defined   -> yq_o is y_o registered on clock_i (1-cycle
//                              latency, synchronous active-high reset to 0)
//                 undefined -> yq_o is a continuous alias of y_o; clock_i and
//                              reset_i are present but unused
//
// Ports       : clock_i  in   1      system clock, rising edge
//               reset_i  in   1      synchronous active-high reset (yq_o only)
//               w_i      in   N_SEL  binary select code
//               en_i     in   1      enable; 0 forces all outputs low
//               y_o      out  N_OUT  combinational one-hot decode of w_i
//               yq_o     out  N_OUT  registered / pass-through copy of y_o
//
// Parameters  : N_SEL     select field width (N_OUT = 2**N_SEL)
//               MSB_FIRST 1: code k asserts bit N_OUT-1-k; 0: asserts bit k
// Revision    : 1.0 - initial release
// ============================================================================
module decode_3_8_bits
    import decode_pkg::*;
#(
    parameter int N_SEL     = DEC_SEL_W,
    parameter bit MSB_FIRST = 1'b1,
    localparam int N_OUT    = 2**N_SEL
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [N_SEL-1:0] w_i,
    input  logic             en_i,
    output logic [N_OUT-1:0] y_o,
    output logic [N_OUT-1:0] yq_o
);

    logic [N_OUT-1:0] y_d;

    // Equality compare per output bit rather than a shift: an X/Z on w_i
    // makes every compare false, so the vector falls to all-zero instead of
    // propagating X. The result is one-hot or zero by construction.
    always_comb begin
        y_d = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (en_i && (w_i == N_SEL'(k))) begin
                if (MSB_FIRST) begin
                    y_d[N_OUT-1-k] = 1'b1;
                end else begin
                    y_d[k] = 1'b1;
                end
            end
        end
    end

    assign y_o = y_d;

`ifdef DECODE_3_8_BITS_REG_OUT_EN

    logic [N_OUT-1:0] yq_q;

    // Reset takes priority over any simultaneous change on w_i / en_i.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            yq_q <= '0;
        end else begin
            yq_q <= y_d;
        end
    end

    assign yq_o = yq_q;

`else

    assign yq_o = y_d;

    // Clock and reset are kept on the port list so both builds share one
    // footprint; fold them into a sink so they are not reported as unused.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = &{1'b0, clock_i, reset_i};

`endif

endmodule : decode_3_8_bits
`default_nettype wire

// File: tb/tb_decode_3_8_bits.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_3_8_bits
// Description : Self-checking bench for decode_3_8_bits. Two instances:
//               MSB_FIRST=1 (main) and MSB_FIRST=0. Expected values are
//               pushed to a scoreboard queue when stimulus is applied and
//               popped when the output is sampled. Registered-output checks
//               are selected by DECODE_3_8_BITS_REG_OUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_3_8_bits;
    import decode_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] w;
    logic       en;
    reg_sel_t   y;
    reg_sel_t   yq;

    logic [2:0] w1;
    logic       en1;
    reg_sel_t   y1;
    reg_sel_t   yq1;

    int checks;
    int failures;

    logic [7:0] sb_q[$];

    decode_3_8_bits #(.N_SEL(3), .MSB_FIRST(1'b1)) u_dut (
        .clock_i (clk),
        .reset_i (rst),
        .w_i     (w),
        .en_i    (en),
        .y_o     (y),
        .yq_o    (yq)
    );

    decode_3_8_bits #(.N_SEL(3), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clock_i (clk),
        .reset_i (rst),
        .w_i     (w1),
        .en_i    (en1),
        .y_o     (y1),
        .yq_o    (yq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written as a shift, independent of the DUT's compare loop.
    function automatic logic [7:0] model(input logic [2:0] sel, input logic ena, input bit msb);
        logic [7:0] r;
        if (!ena) r = 8'h00;
        else if (msb) r = 8'h80 >> sel;
        else r = 8'h01 << sel;
        return r;
    endfunction

    task automatic push(input logic [7:0] v);
        sb_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] exp_v;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp_v = sb_q.pop_front();
            assert (obs === exp_v) else begin
                failures++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic check_onehot(input string tag, input logic [7:0] obs);
        checks++;
        assert ($countones(obs) == 1) else begin
            failures++;
            $error("FAIL %s: observed %h expected exactly one bit set", tag, obs);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; w = 3'd0; en = 1'b0;
        w1  = 3'd0; en1 = 1'b0;

        // Reset / idle state: enable low forces zero.
        @(negedge clk);
        #1;
        push(8'h00); check("idle_y", y);

        // Sweep with enable high, MSB-first.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            w = 3'(i); en = 1'b1;
            push(model(3'(i), 1'b1, 1'b1));
            #1;
            check($sformatf("sweep_y_w%0d", i), y);
            check_onehot($sformatf("sweep_onehot_w%0d", i), y);
`ifndef DECODE_3_8_BITS_REG_OUT_EN
            push(model(3'(i), 1'b1, 1'b1));
            check($sformatf("sweep_yq_alias_w%0d", i), yq);
`endif
        end

        // Enable low: every code decodes to zero.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            w = 3'(i); en = 1'b0;
            push(8'h00);
            #1;
            check($sformatf("disabled_y_w%0d", i), y);
        end

        // Re-enable with W=3: immediate response.
        @(negedge clk);
        w = 3'd3; en = 1'b1;
        push(8'h10);
        #1;
        check("reenable_y_w3", y);

        // LSB-first instance.
        @(negedge clk);
        en1 = 1'b1;
        w1 = 3'd0; push(8'h01); #1; check("lsb_y_w0", y1);
        w1 = 3'd5; push(8'h20); #1; check("lsb_y_w5", y1);
        w1 = 3'd7; push(8'h80); #1; check("lsb_y_w7", y1);

`ifdef DECODE_3_8_BITS_REG_OUT_EN
        // Reset held for two edges clears the register.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        push(8'h00); check("reg_reset_yq", yq);

        // Release reset, W=2: Y immediate, Yq only after the next edge.
        @(negedge clk);
        rst = 1'b0; w = 3'd2; en = 1'b1;
        #1;
        push(8'h20); check("reg_w2_y", y);
        push(8'h00); check("reg_w2_yq_before_edge", yq);
        @(posedge clk); #1;
        push(8'h20); check("reg_w2_yq_after_edge", yq);

        // Settle W=1 then change to 6 on the same edge reset is asserted.
        @(negedge clk);
        w = 3'd1;
        @(posedge clk); #1;
        push(8'h40); check("reg_w1_yq", yq);
        @(negedge clk);
        w = 3'd6; rst = 1'b1;
        @(posedge clk); #1;
        push(8'h00); check("reg_reset_wins_yq", yq);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        push(8'h02); check("reg_resume_w6_yq", yq);

        // LSB-first instance registers too.
        push(8'h80); check("reg_lsb_yq_w7", yq1);
`else
        // Pass-through: Yq follows Y without a clock edge.
        @(negedge clk);
        w = 3'd4; en = 1'b1;
        #1;
        push(8'h08); check("alias_w4_yq", yq);
        rst = 1'b1;
        #1;
        push(8'h08); check("alias_rst_high_yq", yq);
        rst = 1'b0;
        #1;
        push(8'h08); check("alias_rst_low_yq", yq);
        push(8'h80); check("alias_lsb_yq_w7", yq1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decode_3_8_bits
`default_nettype wire

// File: doc/decode_3_8_bits.md
Name: decode_3_8_bits

Overview:
- 3-to-8 one-hot decoder with enable, used by the processor control unit.
- Turns the Rx/Ry instruction fields (IR[5:3], IR[2:0]) into R0..R7 in/out select vectors.
- Provides a combinational output plus a clocked copy. The clocked copy gives downstream logic a glitch-free, one-cycle-delayed select.
- Bit ordering is MSB-first: register code 000 selects bit 7 (R0), matching the control unit's Rin/Rout convention.

Parameters:
- N_SEL, 3, select field width. Output width N_OUT = 2**N_SEL is a derived localparam, default 8.
- MSB_FIRST, 1. When 1, code k asserts Y[N_OUT-1-k]. When 0, code k asserts Y[k].

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- W  input  N_SEL (3)  binary select code.
- En  input  1  decoder enable; 0 forces all outputs low.
- Y  output  N_OUT (8)  combinational one-hot decode of W, gated by En.
- Yq  output  N_OUT (8)  registered (or pass-through) copy of Y; see Optional Feature.

Behaviour:
- Combinational path:
  - En=1, MSB_FIRST=1: Y = 8'b1000_0000 >> W. So 000->1000_0000, 001->0100_0000, ..., 111->0000_0001.
  - En=1, MSB_FIRST=0: Y = 8'b0000_0001 << W.
  - En=0: Y = 0, regardless of W.
  - Y is always one-hot or all-zero; never more than one bit high.
- No X propagation from valid inputs. If W contains X/Z, Y is driven to all-zero; the synthesis default branch is all-zero.
- Registered path (macro defined):
  - On each rising Clock edge: if Reset=1, Yq <= 0; else Yq <= Y.
  - Latency is exactly 1 cycle from W/En change to Yq.
  - Reset value of Yq is 8'h00; Y itself has no reset, since it is purely a function of W and En.
  - Reset and an En/W change in the same cycle: Reset wins, and Yq=0 for that edge. The next edge captures the current Y.
  - Reset deasserted mid-sequence: no internal state beyond Yq, so the decoder resumes immediately.
- No handshake; inputs may change every cycle.
- Clock and Reset affect only Yq; they have no influence on Y.

Optional Feature:
- Macro DECODE_3_8_BITS_REG_OUT_EN.
- Defined: Yq is the registered copy described above (1-cycle latency, synchronous reset to 0).
- Not defined: Yq is a continuous alias of Y (zero latency). Clock and Reset remain ports but are unused; no flops are inferred.
- Y behaviour is identical in both builds.

Decomposition:
- Shared package decode_pkg holds:
  - localparam DEC_SEL_W = 3;
  - localparam DEC_OUT_W = 8;
  - a typedef for the 8-bit register-select vector (reg_sel_t), shared with the control unit's Rin/Rout.
- No sub-module is needed. The optional output register is a single always block in this module, and a separate flop module adds nothing.

Test Plan:
- Sweep W=0..7 with En=1, MSB_FIRST=1 -> Y = 80,40,20,10,08,04,02,01 (hex); each vector checked for exactly one bit high.
- En=0 with W swept 0..7 -> Y=00 every time. Then toggle En back to 1 with W=3 -> Y=10 immediately.
- MSB_FIRST=0 instance, W=0,5,7 with En=1 -> Y=01,20,80.
- Macro defined: Reset=1 for 2 cycles -> Yq=00. Then, with Reset=0, apply W=2, En=1 -> Y=20 at once, and Yq=20 after the next rising edge (not before).
- Macro defined: Reset=1 at the same edge W changes 1->6 -> Yq=00 after that edge. Deassert Reset -> Yq=02 one edge later.
- Macro undefined: W=4, En=1 -> Yq=08 with no clock edges applied. Toggling Reset -> no change in Yq.
